// File: rtl/pong_pkg.sv
// pong_pkg: pong game types and default ball/paddle geometry
package pong_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, MISS} ball_state_t;
  localparam int DEF_H_PIX = vga_pkg::H_PIX;
  localparam int DEF_V_PIX = vga_pkg::V_PIX;
  localparam int DEF_BALL_SIZE = 15;
  localparam int DEF_PAD_H = 145;
  localparam int DEF_X_PAD_L = 30;
  localparam int DEF_X_PAD_R = 979;
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: VGA playfield geometry shared across the video pipeline
package vga_pkg;
  localparam int H_PIX = 1024;
  localparam int V_PIX = 768;
endpackage

// File: rtl/ball_axis_step.sv
// ball_axis_step: clamped single-axis step, snaps to lo/hi and flags a bounce
//   pos, step, lo, hi : 12-bit current coordinate, step size and clamp limits
//   fwd               : 1 = moving toward hi, 0 = moving toward lo
//   nxt, bounce       : stepped coordinate and "limit reached" flag
module ball_axis_step (
  input  logic [11:0] pos,
  input  logic [11:0] step,
  input  logic [11:0] lo,
  input  logic [11:0] hi,
  input  logic        fwd,
  output logic [10:0] nxt,
  output logic        bounce
);
  assign bounce = fwd ? (pos + step >= hi) : (pos <= lo + step);
  assign nxt = 11'(bounce ? (fwd ? hi : lo) : (fwd ? pos + step : pos - step));
endmodule

// File: rtl/ball_physics.sv
// ball_physics: pong ball motion, wall/paddle bounces, speed-up and serve/score FSM
//   clk, rst_n          : clock, synchronous active-low reset
//   timing_tick, serve  : frame strobe (all motion), serve request (IDLE only)
//   y_pad_left/right    : paddle top y
//   x_ball, y_ball      : registered ball top-left
//   hit, miss_left/right: one-clk event pulses; speed: px per tick
import pong_pkg::*;
module ball_physics #(
  parameter int H_PIX       = DEF_H_PIX,
  parameter int V_PIX       = DEF_V_PIX,
  parameter int BALL_SIZE   = DEF_BALL_SIZE,
  parameter int PAD_H       = DEF_PAD_H,
  parameter int X_PAD_L     = DEF_X_PAD_L,
  parameter int X_PAD_R     = DEF_X_PAD_R,
  parameter int V_INIT      = 2,
  parameter int V_MAX       = 6,
  parameter int AUTO_SERVE  = 1,
  parameter int SERVE_DELAY = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timing_tick,
  input  logic        serve,
  input  logic [9:0]  y_pad_left,
  input  logic [9:0]  y_pad_right,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic        hit,
  output logic        miss_left,
  output logic        miss_right,
  output logic [2:0]  speed
);
  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [10:0] X_MID = 11'((H_PIX - BALL_SIZE) / 2);
  localparam logic [10:0] Y_MID = 11'((V_PIX - BALL_SIZE) / 2);
  localparam logic [11:0] BS = 12'(BALL_SIZE);
  localparam logic [11:0] PH = 12'(PAD_H);
  localparam logic [11:0] HALF = 12'(BALL_SIZE / 2);
  localparam logic [11:0] THIRD = 12'(PAD_H / 3);
  localparam logic [11:0] TWO_THIRD = 12'(2 * PAD_H / 3);
  localparam logic [11:0] Y_MAX = 12'(V_PIX - BALL_SIZE);
  localparam logic [11:0] X_MAX = 12'(H_PIX - BALL_SIZE);
  localparam logic [11:0] XL = 12'(X_PAD_L);
  localparam logic [11:0] XR = 12'(X_PAD_R - BALL_SIZE);
  localparam logic [2:0] VIN = 3'(V_INIT);
  localparam logic [2:0] VMX = 3'(V_MAX);
  ball_state_t state, state_next;
  logic dir_x, dir_y, dy_wall, dy_next, ovl_l, ovl_r, ovl, wall, edge_x, pad_hit, out_miss, auto_go;
  logic [CW-1:0] serve_cnt;
  logic [11:0] s, pl, pr, pad, c, y_w, x_w;
  logic [10:0] nx, ny;
  assign s = {9'd0, speed};
  assign pl = {2'b0, y_pad_left};
  assign pr = {2'b0, y_pad_right};
  assign y_w = {1'b0, y_ball};
  assign x_w = {1'b0, x_ball};
  assign c = y_w + HALF;
  assign ovl_l = (y_w + BS > pl) && (y_w < pl + PH);
  assign ovl_r = (y_w + BS > pr) && (y_w < pr + PH);
  assign pad = dir_x ? pr : pl;
  assign ovl = dir_x ? ovl_r : ovl_l;
  // An overlapping paddle moves the x clamp from the playfield edge to the paddle face
  ball_axis_step u_y (.pos(y_w), .step(s), .lo(12'd0), .hi(Y_MAX), .fwd(dir_y), .nxt(ny), .bounce(wall));
  ball_axis_step u_x (.pos(x_w), .step(s), .lo(ovl ? XL : 12'd0), .hi(ovl ? XR : X_MAX),
                      .fwd(dir_x), .nxt(nx), .bounce(edge_x));
  assign pad_hit = edge_x & ovl;
  assign out_miss = edge_x & ~ovl;
  assign dy_wall = wall ? ~dir_y : dir_y;
  // Paddle zone override: top third sends the ball up, bottom third down
  assign dy_next = pad_hit ? (c < pad + THIRD ? 1'b0 : c >= pad + TWO_THIRD ? 1'b1 : dy_wall) : dy_wall;
  assign auto_go = (AUTO_SERVE != 0) && timing_tick && (serve_cnt == CW'(SERVE_DELAY - 1));
  always_comb begin
    state_next = state;
    state_next = state == IDLE ? ((serve || auto_go) ? PLAY : IDLE) :
                 state == PLAY ? ((timing_tick && out_miss) ? MISS : PLAY) :
                 (timing_tick ? IDLE : state);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      x_ball <= X_MID;
      y_ball <= Y_MID;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
      speed <= VIN;
      hit <= 1'b0;
      miss_left <= 1'b0;
      miss_right <= 1'b0;
      serve_cnt <= '0;
    end else begin
      state <= state_next;
      hit <= 1'b0;
      miss_left <= 1'b0;
      miss_right <= 1'b0;
      serve_cnt <= (state != IDLE || state_next != IDLE) ? '0 : serve_cnt + CW'(timing_tick);
      if (state == PLAY && timing_tick) begin
        x_ball <= nx;
        y_ball <= ny;
        dir_y <= dy_next;
        hit <= pad_hit;
        miss_left <= out_miss & ~dir_x;
        miss_right <= out_miss & dir_x;
        // dir_x is left pointing at the losing side on a miss, so the next serve goes there
        if (pad_hit) begin
          dir_x <= ~dir_x;
          speed <= speed == VMX ? speed : speed + 3'd1;
        end
      end
      if (state == MISS && timing_tick) begin
        x_ball <= X_MID;
        y_ball <= Y_MID;
        speed <= VIN;
      end
    end
  end
endmodule

// File: tb/tb_ball_physics.sv
// tb_ball_physics: scoreboard bench for ball_physics
module tb_ball_physics;
  import pong_pkg::*;
  typedef struct {int x; int y; int spd; bit h; bit ml; bit mr;} exp_t;
  logic clk = 0, rst_n = 0, timing_tick = 0, serve = 0;
  logic [9:0] y_pad_left = 10'd90, y_pad_right = 10'd1000;
  logic [10:0] x_ball, y_ball, ax, ay;
  logic hit, miss_left, miss_right, ah, aml, amr;
  logic [2:0] speed, aspd;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  ball_state_t m_state;
  int m_x, m_y, m_spd, m_hits;
  bit m_dx, m_dy, last_h, last_ml, last_mr;
  always #5 clk = ~clk;
  ball_physics #(.AUTO_SERVE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .timing_tick(timing_tick), .serve(serve),
    .y_pad_left(y_pad_left), .y_pad_right(y_pad_right), .x_ball(x_ball), .y_ball(y_ball),
    .hit(hit), .miss_left(miss_left), .miss_right(miss_right), .speed(speed));
  ball_physics u_auto (
    .clk(clk), .rst_n(rst_n), .timing_tick(timing_tick), .serve(1'b0),
    .y_pad_left(y_pad_left), .y_pad_right(y_pad_right), .x_ball(ax), .y_ball(ay),
    .hit(ah), .miss_left(aml), .miss_right(amr), .speed(aspd));

  task automatic model_reset;
    m_state = IDLE; m_x = 504; m_y = 376; m_spd = 2; m_dx = 0; m_dy = 0;
    q.delete();
  endtask

  task automatic model_step(input bit srv);
    int s, pl, pr, pad, yo;
    bit ol, orr, h, ml, mr;
    exp_t e;
    h = 0; ml = 0; mr = 0; pad = 0;
    if (m_state == IDLE) begin
      if (srv) m_state = PLAY;
    end else if (m_state == MISS) begin
      m_x = 504; m_y = 376; m_spd = 2; m_state = IDLE;
    end else begin
      s = m_spd; pl = int'(y_pad_left); pr = int'(y_pad_right); yo = m_y;
      ol = (yo + 15 > pl) && (yo < pl + 145);
      orr = (yo + 15 > pr) && (yo < pr + 145);
      if (m_dy) begin
        if (yo + s >= 753) begin m_y = 753; m_dy = 0; end else m_y = yo + s;
      end else begin
        if (yo <= s) begin m_y = 0; m_dy = 1; end else m_y = yo - s;
      end
      if (m_dx) begin
        if (m_x + 15 + s >= 979 && orr) begin m_x = 964; m_dx = 0; h = 1; pad = pr; end
        else if (m_x + 15 + s >= 1024) begin m_x = 1009; mr = 1; m_state = MISS; end
        else m_x = m_x + s;
      end else begin
        if (m_x <= 30 + s && ol) begin m_x = 30; m_dx = 1; h = 1; pad = pl; end
        else if (m_x <= s) begin m_x = 0; ml = 1; m_state = MISS; end
        else m_x = m_x - s;
      end
      if (h) begin
        m_hits++;
        m_spd = m_spd < 6 ? m_spd + 1 : 6;
        if (yo + 7 < pad + 48) m_dy = 0;
        else if (yo + 7 >= pad + 96) m_dy = 1;
      end
    end
    e = '{m_x, m_y, m_spd, h, ml, mr};
    q.push_back(e);
  endtask

  task automatic do_tick(input bit srv);
    exp_t e;
    model_step(srv);
    timing_tick = 1; serve = srv;
    @(negedge clk);
    timing_tick = 0; serve = 0;
    e = q.pop_front();
    n_chk++;
    if ({x_ball, y_ball} !== {11'(e.x), 11'(e.y)}) begin
      n_fail++; $display("FAIL pos: got x=%0d y=%0d expected x=%0d y=%0d", x_ball, y_ball, e.x, e.y);
    end
    n_chk++;
    if (speed !== 3'(e.spd)) begin n_fail++; $display("FAIL speed: got %0d expected %0d", speed, e.spd); end
    n_chk++;
    if ({hit, miss_left, miss_right} !== {e.h, e.ml, e.mr}) begin
      n_fail++; $display("FAIL pulses: got h/ml/mr=%b%b%b expected %b%b%b", hit, miss_left, miss_right, e.h, e.ml, e.mr);
    end
    last_h = hit; last_ml = miss_left; last_mr = miss_right;
    @(negedge clk);
    n_chk++;
    if ({hit, miss_left, miss_right} !== 3'b000) begin
      n_fail++; $display("FAIL pulse_width: got h/ml/mr=%b%b%b expected 000", hit, miss_left, miss_right);
    end
  endtask

  task automatic serve_only;
    serve = 1;
    @(negedge clk);
    serve = 0;
    if (m_state == IDLE) m_state = PLAY;
  endtask

  task automatic test_reset;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    n_chk++;
    if ({x_ball, y_ball, speed} !== {11'd504, 11'd376, 3'd2}) begin
      n_fail++; $display("FAIL reset: got x=%0d y=%0d spd=%0d expected 504 376 2", x_ball, y_ball, speed);
    end
    n_chk++;
    if ({hit, miss_left, miss_right} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b%b%b expected 000", hit, miss_left, miss_right);
    end
  endtask

  task automatic test_serve;
    do_tick(0);
    serve_only();
    do_tick(0);
    n_chk++;
    if ({x_ball, y_ball} !== {11'd502, 11'd374}) begin
      n_fail++; $display("FAIL first_serve: got %0d,%0d expected 502,374", x_ball, y_ball);
    end
  endtask

  task automatic test_top_wall;
    repeat (187) do_tick(0);
    n_chk++;
    if ({x_ball, y_ball} !== {11'd128, 11'd0}) begin
      n_fail++; $display("FAIL top_wall: got %0d,%0d expected 128,0", x_ball, y_ball);
    end
    do_tick(0);
    n_chk++;
    if ({x_ball, y_ball, last_h} !== {11'd126, 11'd2, 1'b0}) begin
      n_fail++; $display("FAIL wall_rebound: got %0d,%0d hit=%b expected 126,2 hit=0", x_ball, y_ball, last_h);
    end
  endtask

  task automatic test_left_paddle;
    repeat (47) do_tick(0);
    do_tick(0);
    n_chk++;
    if ({x_ball, y_ball, speed, last_h} !== {11'd30, 11'd98, 3'd3, 1'b1}) begin
      n_fail++; $display("FAIL left_hit: got x=%0d y=%0d spd=%0d hit=%b expected 30 98 3 1", x_ball, y_ball, speed, last_h);
    end
    do_tick(0);
    n_chk++;
    if ({x_ball, y_ball} !== {11'd33, 11'd95}) begin
      n_fail++; $display("FAIL top_zone: got %0d,%0d expected 33,95", x_ball, y_ball);
    end
  endtask

  task automatic test_right_miss;
    y_pad_right = 10'd1000;
    for (int i = 0; i < 500 && m_state != MISS; i++) do_tick(0);
    n_chk++;
    if ({last_mr, last_ml, x_ball} !== {1'b1, 1'b0, 11'd1009}) begin
      n_fail++; $display("FAIL right_miss: got mr=%b ml=%b x=%0d expected 1 0 1009", last_mr, last_ml, x_ball);
    end
    do_tick(0);
    n_chk++;
    if ({x_ball, y_ball, speed} !== {11'd504, 11'd376, 3'd2}) begin
      n_fail++; $display("FAIL recentre: got %0d,%0d spd=%0d expected 504,376 2", x_ball, y_ball, speed);
    end
    serve_only();
    do_tick(0);
    n_chk++;
    if (x_ball !== 11'd506) begin n_fail++; $display("FAIL serve_right: got x=%0d expected 506", x_ball); end
  endtask

  task automatic test_saturation;
    int start;
    logic [10:0] y_hit;
    start = m_hits;
    for (int i = 0; i < 4000 && m_hits < start + 10; i++) begin
      y_pad_left = m_y >= 20 ? 10'(m_y - 20) : 10'd0;
      y_pad_right = y_pad_left;
      do_tick(0);
    end
    n_chk++;
    if (speed !== 3'd6 || m_hits < start + 10) begin
      n_fail++; $display("FAIL saturation: got spd=%0d hits=%0d expected 6 10", speed, m_hits - start);
    end
    y_hit = y_ball;
    do_tick(0);
    if (y_hit > 11'd6) begin
      n_chk++;
      if (y_ball !== y_hit - 11'd6) begin
        n_fail++; $display("FAIL zone_up: got y=%0d expected %0d", y_ball, y_hit - 11'd6);
      end
    end
  endtask

  task automatic test_serve_with_tick;
    do_tick(1);
    n_chk++;
    if (x_ball !== 11'd504) begin n_fail++; $display("FAIL serve_tick_still: got x=%0d expected 504", x_ball); end
    do_tick(0);
    n_chk++;
    if ({x_ball, y_ball} !== {11'd502, 11'd374}) begin
      n_fail++; $display("FAIL serve_tick_move: got %0d,%0d expected 502,374", x_ball, y_ball);
    end
  endtask

  task automatic test_left_miss;
    y_pad_left = 10'd1000;
    for (int i = 0; i < 500 && m_state != MISS; i++) do_tick(0);
    n_chk++;
    if ({last_ml, last_mr, x_ball} !== {1'b1, 1'b0, 11'd0}) begin
      n_fail++; $display("FAIL left_miss: got ml=%b mr=%b x=%0d expected 1 0 0", last_ml, last_mr, x_ball);
    end
    do_tick(0);
    serve_only();
    do_tick(0);
    n_chk++;
    if (x_ball !== 11'd502) begin n_fail++; $display("FAIL serve_left: got x=%0d expected 502", x_ball); end
  endtask

  task automatic test_auto_serve;
    test_reset();
    repeat (120) do_tick(0);
    n_chk++;
    if ({ax, ay} !== {11'd504, 11'd376}) begin
      n_fail++; $display("FAIL auto_hold: got %0d,%0d expected 504,376", ax, ay);
    end
    do_tick(0);
    n_chk++;
    if ({ax, ay} !== {11'd502, 11'd374}) begin
      n_fail++; $display("FAIL auto_serve: got %0d,%0d expected 502,374", ax, ay);
    end
  endtask

  initial begin
    m_hits = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_serve();
    test_top_wall();
    test_left_paddle();
    test_right_miss();
    test_saturation();
    test_reset();
    test_serve_with_tick();
    test_left_miss();
    test_auto_serve();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
